cam_frame_capture: RTL and testbench

CAM_FRAME_CAPTURE -- requirements
Module: cam_frame_capture

---
 rtl/cam_frame_capture.sv | 171 +++++++++++++++++
 tb/tb_cam_frame_capture.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/cam_frame_capture.sv
// cam_frame_capture: captures a two-byte-per-pixel camera stream, decimates it
// by 2^DEC_SHIFT in both axes and emits sequential frame-buffer writes in
// RGB444 or RGB565, with line-length and frame-height integrity checking.
module cam_frame_capture #(
  parameter int H_ACT     = 640,
  parameter int V_ACT     = 480,
  parameter int DEC_SHIFT = 1,
  parameter int ADDR_W    = 17
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              vsync,
  input  logic              href,
  input  logic [7:0]        p_data,
  input  logic              cap_en,
  input  logic              fmt_sel,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [15:0]       wr_data,
  output logic              wr_en,
  output logic              frame_done,
  output logic              busy,
  output logic              cap_err,
  output logic [7:0]        frame_cnt
);

  localparam int CW       = 16;
  localparam int MAX_ADDR = (H_ACT >> DEC_SHIFT) * (V_ACT >> DEC_SHIFT) - 1;
  localparam logic [CW-1:0] DEC_MASK = CW'((1 << DEC_SHIFT) - 1);

  typedef enum logic [1:0] {IDLE, WAIT_VS, CAPTURE} state_t;

  state_t          state;
  logic            vs_r, vs_q, href_r, href_q, cap_en_q;
  logic [7:0]      pd_r, hi_byte;
  logic            fmt_q, phase, frame_bad;
  logic [CW-1:0]   x, y;
  logic [ADDR_W:0] addr_cnt;

  logic        vs_fall, vs_rise, href_fall, cap_en_rise, take_pix;
  logic [15:0] pix_565, pix_444;

  assign vs_fall     = vs_q & ~vs_r;
  assign vs_rise     = vs_r & ~vs_q;
  assign href_fall   = href_q & ~href_r;
  assign cap_en_rise = cap_en & ~cap_en_q;
  assign pix_565     = {hi_byte, pd_r};
  assign pix_444     = {4'h0, hi_byte[7:4], hi_byte[2:0], pd_r[7], pd_r[4:1]};

  // A completed pixel is kept only on the decimation grid and inside the active window.
  assign take_pix = (state == CAPTURE) && href_r && phase &&
                    ((x & DEC_MASK) == '0) && ((y & DEC_MASK) == '0) &&
                    (x < CW'(H_ACT)) && (y < CW'(V_ACT));

  // Input registers: one stage on the camera signals, plus edge-detect history.
  // NOTE: sequential state uses <= so every register samples pre-edge values;
  // blocking here would let href_q see the new href_r and hide the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vs_r     <= 1'b0;
      vs_q     <= 1'b0;
      href_r   <= 1'b0;
      href_q   <= 1'b0;
      pd_r     <= 8'h00;
      cap_en_q <= 1'b0;
    end else begin
      vs_r     <= vsync;
      vs_q     <= vs_r;
      href_r   <= href;
      href_q   <= href_r;
      pd_r     <= p_data;
      cap_en_q <= cap_en;
    end
  end

  // Capture FSM with byte/pixel/line tracking and registered write-port outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      fmt_q      <= 1'b0;
      phase      <= 1'b0;
      hi_byte    <= 8'h00;
      x          <= '0;
      y          <= '0;
      addr_cnt   <= '0;
      frame_bad  <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= 16'h0000;
      wr_en      <= 1'b0;
      frame_done <= 1'b0;
      busy       <= 1'b0;
      cap_err    <= 1'b0;
      frame_cnt  <= 8'h00;
    end else begin
      // NOTE: pulse outputs are defaulted low every cycle; each path below
      // only raises them, so no branch can leave them stuck or unassigned.
      wr_en      <= 1'b0;
      frame_done <= 1'b0;
      if (cap_en_rise) cap_err <= 1'b0;

      // Byte pairing: phase 0 holds the high byte, phase 1 completes a pixel.
      if (href_r) begin
        phase <= ~phase;
        if (!phase)         hi_byte <= pd_r;
        else if (x != '1)   x       <= x + 1'b1;
      end else begin
        phase <= 1'b0;
      end

      if (href_fall) begin
        if ((x != '0) && (y != '1)) y <= y + 1'b1;
        x <= '0;
      end

      case (state)
        IDLE: begin
          if (cap_en) state <= WAIT_VS;
        end

        WAIT_VS: begin
          if (!cap_en) begin
            state <= IDLE;
          end else if (vs_fall) begin
            state     <= CAPTURE;
            busy      <= 1'b1;
            fmt_q     <= fmt_sel;
            x         <= '0;
            y         <= '0;
            addr_cnt  <= '0;
            frame_bad <= 1'b0;
          end
        end

        CAPTURE: begin
          if (take_pix) begin
            if (addr_cnt > (ADDR_W+1)'(MAX_ADDR)) begin
              cap_err   <= 1'b1;
              frame_bad <= 1'b1;
            end else begin
              wr_en    <= 1'b1;
              wr_addr  <= addr_cnt[ADDR_W-1:0];
              wr_data  <= fmt_q ? pix_565 : pix_444;
              addr_cnt <= addr_cnt + 1'b1;
            end
          end
          // Short, long or odd-byte lines poison the frame; the partial
          // pixel is dropped because phase clears while href is low.
          if (href_fall && ((x != CW'(H_ACT)) || phase)) begin
            cap_err   <= 1'b1;
            frame_bad <= 1'b1;
          end
          if (vs_rise) begin
            state <= cap_en ? WAIT_VS : IDLE;
            busy  <= 1'b0;
            if ((y == CW'(V_ACT)) && !frame_bad) begin
              frame_done <= 1'b1;
              frame_cnt  <= frame_cnt + 1'b1;
            end else begin
              cap_err <= 1'b1;
            end
          end
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cam_frame_capture.sv
// Directed bench for cam_frame_capture with an 8x4 active window, 2x decimation.
module tb_cam_frame_capture;

  localparam int H = 8;
  localparam int V = 4;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          rst_n, vsync, href, cap_en, fmt_sel;
  logic [7:0]    p_data;
  logic [AW-1:0] wr_addr;
  logic [15:0]   wr_data;
  logic          wr_en, frame_done, busy, cap_err;
  logic [7:0]    frame_cnt;

  cam_frame_capture #(.H_ACT(H), .V_ACT(V), .DEC_SHIFT(1), .ADDR_W(AW)) dut (
    .clk(clk), .rst_n(rst_n), .vsync(vsync), .href(href), .p_data(p_data),
    .cap_en(cap_en), .fmt_sel(fmt_sel), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_en(wr_en), .frame_done(frame_done), .busy(busy), .cap_err(cap_err),
    .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Cycle counter and write/frame_done monitor, sampled on the falling edge.
  int            cyc = 0;
  int            nw_total = 0;
  int            done_cnt = 0;
  int            done_long = 0;
  logic          done_prev = 1'b0;
  logic [AW-1:0] wa [4096];
  logic [15:0]   wd [4096];
  int            wcyc [4096];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (wr_en) begin
      if (nw_total < 4096) begin
        wa[nw_total]   = wr_addr;
        wd[nw_total]   = wr_data;
        wcyc[nw_total] = cyc;
      end
      nw_total = nw_total + 1;
    end
    if (frame_done) begin
      done_cnt = done_cnt + 1;
      if (done_prev) done_long = done_long + 1;
    end
    done_prev = frame_done;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Values captured inside send_frame for later checking.
  int            t_second;
  logic          busy_mid;
  logic          rst_wr_en;
  logic [AW-1:0] rst_wr_addr;
  int            nw_at_rst;

  // One frame: vsync blanking, nlines lines of nbytes (bad_line gets bad_bytes),
  // optional mid-line event: 1 = toggle fmt_sel, 2 = drop cap_en, 3 = reset pulse.
  task automatic send_frame(input int nlines, input int nbytes, input int bad_line,
                            input int bad_bytes, input bit pattern,
                            input logic [7:0] hi_c, input logic [7:0] lo_c,
                            input int ev_line, input int ev_kind);
    int nb, px;
    logic [7:0] hi;
    vsync = 1'b1;
    repeat (4) @(negedge clk);
    vsync = 1'b0;
    repeat (4) @(negedge clk);
    for (int l = 0; l < nlines; l++) begin
      nb = (l == bad_line) ? bad_bytes : nbytes;
      for (int b = 0; b < nb; b++) begin
        px = b / 2;
        hi = pattern ? {4'(l), 4'(px)} : hi_c;
        href = 1'b1;
        p_data = (b % 2 == 0) ? hi : (pattern ? (hi ^ 8'hA5) : lo_c);
        if (l == 0 && b == 1) t_second = cyc;
        if (l == 0 && b == 4) busy_mid = busy;
        if (l == ev_line && b == 6) begin
          if (ev_kind == 1) fmt_sel = ~fmt_sel;
          if (ev_kind == 2) cap_en = 1'b0;
          if (ev_kind == 3) begin
            #2 rst_n = 1'b0;
            #1 rst_wr_en = wr_en;
            rst_wr_addr = wr_addr;
            nw_at_rst = nw_total;
            #3 rst_n = 1'b1;
          end
        end
        @(negedge clk);
      end
      href = 1'b0;
      p_data = 8'h00;
      repeat (4) @(negedge clk);
    end
    vsync = 1'b1;
    repeat (6) @(negedge clk);
  endtask

  int base, n, exp_done;
  logic [7:0] phi;

  initial begin
    rst_n = 1'b0; vsync = 1'b1; href = 1'b0; p_data = 8'h00;
    cap_en = 1'b0; fmt_sel = 1'b0;
    exp_done = 0;
    repeat (3) @(negedge clk);
    check("rst_wr_en", wr_en, 0);
    check("rst_wr_addr", wr_addr, 0);
    check("rst_busy", busy, 0);
    check("rst_frame_cnt", frame_cnt, 0);
    check("rst_cap_err", cap_err, 0);
    check("rst_frame_done", frame_done, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // href activity with capture disabled produces nothing.
    base = nw_total;
    send_frame(V, 2*H, -1, 0, 0, 8'hF8, 8'h1F, -1, 0);
    check("idle_no_writes", nw_total - base, 0);
    check("idle_busy", busy, 0);

    // First clean frame, RGB565 with position-coded pixels.
    cap_en = 1'b1; fmt_sel = 1'b1;
    base = nw_total;
    send_frame(V, 2*H, -1, 0, 1, 8'h00, 8'h00, -1, 0);
    exp_done++;
    check("f1_write_count", nw_total - base, 8);
    for (int k = 0; k < 8; k++) begin
      phi = {4'((k / 4) * 2), 4'((k % 4) * 2)};
      check($sformatf("f1_addr%0d", k), wa[base+k], k);
      check($sformatf("f1_data%0d", k), wd[base+k], {phi, phi ^ 8'hA5});
    end
    check("f1_latency", wcyc[base] - t_second, 2);
    check("f1_busy_mid", busy_mid, 1);
    check("f1_busy_after", busy, 0);
    check("f1_done_cnt", done_cnt, exp_done);
    check("f1_done_width", done_long, 0);
    check("f1_frame_cnt", frame_cnt, 1);
    check("f1_cap_err", cap_err, 0);

    // RGB444 packing of 0xF8,0x1F.
    fmt_sel = 1'b0;
    base = nw_total;
    send_frame(V, 2*H, -1, 0, 0, 8'hF8, 8'h1F, -1, 0);
    exp_done++;
    check("f444_count", nw_total - base, 8);
    check("f444_first", wd[base], 16'h0F0F);
    check("f444_last", wd[base+7], 16'h0F0F);
    check("f444_frame_cnt", frame_cnt, 2);

    // RGB565 packing of the same bytes.
    fmt_sel = 1'b1;
    base = nw_total;
    send_frame(V, 2*H, -1, 0, 0, 8'hF8, 8'h1F, -1, 0);
    exp_done++;
    check("f565_first", wd[base], 16'hF81F);

    // fmt_sel flipped mid-frame: packing held until the next frame.
    base = nw_total;
    send_frame(V, 2*H, -1, 0, 0, 8'hF8, 8'h1F, 1, 1);
    exp_done++;
    check("fmt_hold_first", wd[base], 16'hF81F);
    check("fmt_hold_last", wd[base+7], 16'hF81F);
    base = nw_total;
    send_frame(V, 2*H, -1, 0, 0, 8'hF8, 8'h1F, -1, 0);
    exp_done++;
    check("fmt_next_frame", wd[base], 16'h0F0F);
    check("fmt_frame_cnt", frame_cnt, 5);
    check("fmt_done_cnt", done_cnt, exp_done);

    // 15-byte line: error, no completion; cleared by cap_en cycling.
    send_frame(V, 2*H, 1, 15, 0, 8'hF8, 8'h1F, -1, 0);
    check("odd_cap_err", cap_err, 1);
    check("odd_done_cnt", done_cnt, exp_done);
    check("odd_frame_cnt", frame_cnt, 5);
    cap_en = 1'b0; repeat (3) @(negedge clk);
    cap_en = 1'b1; repeat (3) @(negedge clk);
    check("odd_err_cleared", cap_err, 0);

    // 7-pixel line.
    send_frame(V, 2*H, 2, 14, 0, 8'hF8, 8'h1F, -1, 0);
    check("short_cap_err", cap_err, 1);
    check("short_done_cnt", done_cnt, exp_done);
    check("short_frame_cnt", frame_cnt, 5);
    cap_en = 1'b0; repeat (3) @(negedge clk);
    cap_en = 1'b1; repeat (3) @(negedge clk);
    check("short_err_cleared", cap_err, 0);

    // cap_en dropped mid-frame: frame still completes, next frame ignored.
    base = nw_total;
    send_frame(V, 2*H, -1, 0, 0, 8'hF8, 8'h1F, 1, 2);
    exp_done++;
    check("drop_count", nw_total - base, 8);
    check("drop_last_addr", wa[base+7], 7);
    check("drop_frame_cnt", frame_cnt, 6);
    check("drop_busy", busy, 0);
    base = nw_total;
    send_frame(V, 2*H, -1, 0, 0, 8'hF8, 8'h1F, -1, 0);
    check("drop_next_none", nw_total - base, 0);
    check("drop_next_cnt", frame_cnt, 6);
    cap_en = 1'b1;
    repeat (2) @(negedge clk);

    // Reset pulse mid-line in line 1.
    base = nw_total;
    send_frame(V, 2*H, -1, 0, 0, 8'hF8, 8'h1F, 1, 3);
    check("mrst_wr_en", rst_wr_en, 0);
    check("mrst_wr_addr", rst_wr_addr, 0);
    check("mrst_writes_before", nw_at_rst - base, 4);
    check("mrst_no_more_writes", nw_total, nw_at_rst);
    check("mrst_frame_cnt", frame_cnt, 0);
    base = nw_total;
    send_frame(V, 2*H, -1, 0, 0, 8'hF8, 8'h1F, -1, 0);
    exp_done++;
    check("mrst_next_count", nw_total - base, 8);
    check("mrst_next_addr0", wa[base], 0);
    check("mrst_next_addr7", wa[base+7], 7);
    check("mrst_next_cnt", frame_cnt, 1);

    // frame_cnt wrap 255 -> 0 -> 1.
    repeat (254) begin
      send_frame(V, 2*H, -1, 0, 0, 8'hF8, 8'h1F, -1, 0);
      exp_done++;
    end
    check("wrap_255", frame_cnt, 255);
    send_frame(V, 2*H, -1, 0, 0, 8'hF8, 8'h1F, -1, 0);
    exp_done++;
    check("wrap_0", frame_cnt, 0);
    send_frame(V, 2*H, -1, 0, 0, 8'hF8, 8'h1F, -1, 0);
    exp_done++;
    check("wrap_1", frame_cnt, 1);
    check("wrap_done_cnt", done_cnt, exp_done);
    check("wrap_done_width", done_long, 0);
    check("wrap_cap_err", cap_err, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
